// File: rtl/mul_hilo_unit_if.sv
// Decoder/datapath-facing bus of the HI/LO multiply unit: issue controls, operands, read data and stall.
interface mul_hilo_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             domul;
  logic             multoreg;
  logic             lohi;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [WIDTH-1:0] rdata;
  logic             busy;
  logic             stall;

  modport master (
    output domul, multoreg, lohi, srca, srcb,
    input  rdata, busy, stall
  );

  modport slave (
    input  domul, multoreg, lohi, srca, srcb,
    output rdata, busy, stall
  );
endinterface

// File: rtl/mul_hilo_unit.sv
// Iterative unsigned WIDTHxWIDTH multiplier (one shift-add step per clock) with HI/LO registers.
// HI/LO change only at the completion edge, so mfhi/mflo see the previous product until then.
module mul_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_hilo_unit_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH:0]     sum;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    p_d     = p_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sum     = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.domul) begin
          a_d     = bus.srca;
          p_d     = {{WIDTH{1'b0}}, bus.srcb};
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Sum is WIDTH+1 bits so the carry out of the upper half shifts back into P.
        sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, a_q} : '0);
        p_d     = {sum, p_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          hi_d    = p_d[2*WIDTH-1:WIDTH];
          lo_d    = p_d[WIDTH-1:0];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      p_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      p_q     <= p_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    bus.busy  = (state_q == RUN);
    bus.stall = (state_q == RUN) && (bus.domul || bus.multoreg);
    bus.rdata = bus.lohi ? hi_q : lo_q;
  end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Directed-vector bench for mul_hilo_unit: products, latency, stall behaviour and reset abort.
module tb_mul_hilo_unit;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mul_hilo_unit_if #(.WIDTH(32)) bus ();

  mul_hilo_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_mul(input logic [31:0] a, input logic [31:0] b);
    bus.srca  = a;
    bus.srcb  = b;
    bus.domul = 1'b1;
    tick();
    bus.domul = 1'b0;
  endtask

  // Counts edges after E0 until busy drops; bounded so a hung engine cannot stall the bench.
  task automatic wait_done(output int k);
    k = 0;
    while (bus.busy && k < 100) begin
      tick();
      k++;
    end
  endtask

  task automatic read_reg(input logic sel, output logic [31:0] v);
    bus.multoreg = 1'b1;
    bus.lohi     = sel;
    #1;
    v = bus.rdata;
    bus.multoreg = 1'b0;
    bus.lohi     = 1'b0;
    #1;
  endtask

  task automatic mul_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int k;
    logic [31:0] v;
    start_mul(a, b);
    check({tag, "_busy"}, {31'b0, bus.busy}, 32'd1);
    wait_done(k);
    check({tag, "_lat"}, k, 32'd32);
    read_reg(1'b0, v);
    check({tag, "_lo"}, v, exp_lo);
    read_reg(1'b1, v);
    check({tag, "_hi"}, v, exp_hi);
  endtask

  initial begin
    int k;
    logic [31:0] v;
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.domul    = 1'b0;
    bus.multoreg = 1'b0;
    bus.lohi     = 1'b0;
    bus.srca     = '0;
    bus.srcb     = '0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    read_reg(1'b0, v);
    check("rst_lo", v, 32'd0);
    read_reg(1'b1, v);
    check("rst_hi", v, 32'd0);

    // Basic products, including the carry path
    mul_and_check("m3x5", 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
    mul_and_check("mff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    mul_and_check("mmix", 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080);

    // mflo during RUN stalls and shows the old LO, then reads the new product
    mul_and_check("pre", 32'd3, 32'd5, 32'h0, 32'h0000_000F);
    start_mul(32'h0001_0000, 32'h0001_0000);
    repeat (4) tick();
    bus.multoreg = 1'b1;
    bus.lohi     = 1'b0;
    #1;
    check("mf_stall", {31'b0, bus.stall}, 32'd1);
    check("mf_old_lo", bus.rdata, 32'h0000_000F);
    k = 4;
    while (bus.stall && k < 100) begin
      tick();
      k++;
    end
    check("mf_release", k, 32'd32);
    check("mf_new_lo", bus.rdata, 32'h0);
    bus.lohi = 1'b1;
    #1;
    check("mf_new_hi", bus.rdata, 32'h1);
    bus.multoreg = 1'b0;
    bus.lohi     = 1'b0;

    // domul during RUN (held through the completion cycle) is ignored, then restarts
    start_mul(32'd2, 32'd3);
    repeat (9) tick();
    bus.srca  = 32'd7;
    bus.srcb  = 32'd9;
    bus.domul = 1'b1;
    #1;
    check("dm_stall", {31'b0, bus.stall}, 32'd1);
    k = 9;
    while (bus.busy && k < 100) begin
      tick();
      k++;
    end
    check("dm_lat", k, 32'd32);
    check("dm_first_lo", bus.rdata, 32'd6);
    check("dm_idle_stall", {31'b0, bus.stall}, 32'd0);
    tick();
    bus.domul = 1'b0;
    check("dm_restart", {31'b0, bus.busy}, 32'd1);
    wait_done(k);
    check("dm_lat2", k, 32'd32);
    read_reg(1'b0, v);
    check("dm_lo", v, 32'h3F);
    read_reg(1'b1, v);
    check("dm_hi", v, 32'h0);

    // Reset mid-run aborts with no partial write; reset beats a simultaneous domul
    start_mul(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (11) tick();
    reset     = 1'b1;
    bus.domul = 1'b1;
    tick();
    reset     = 1'b0;
    bus.domul = 1'b0;
    bus.multoreg = 1'b1;
    #1;
    check("ra_busy", {31'b0, bus.busy}, 32'd0);
    check("ra_stall", {31'b0, bus.stall}, 32'd0);
    bus.multoreg = 1'b0;
    read_reg(1'b0, v);
    check("ra_lo", v, 32'h0);
    read_reg(1'b1, v);
    check("ra_hi", v, 32'h0);
    tick();
    check("ra_idle", {31'b0, bus.busy}, 32'd0);
    mul_and_check("m2x2", 32'd2, 32'd2, 32'h0, 32'h4);

    // Zero operands keep full latency; domul+multoreg in IDLE does not stall
    bus.srca     = 32'd0;
    bus.srcb     = 32'h1234;
    bus.domul    = 1'b1;
    bus.multoreg = 1'b1;
    #1;
    check("both_idle_stall", {31'b0, bus.stall}, 32'd0);
    tick();
    bus.domul    = 1'b0;
    bus.multoreg = 1'b0;
    check("both_busy", {31'b0, bus.busy}, 32'd1);
    wait_done(k);
    check("za_lat", k, 32'd32);
    read_reg(1'b0, v);
    check("za_lo", v, 32'h0);
    mul_and_check("zb", 32'hDEAD_BEEF, 32'd0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
